// File: rtl/block_sync_ctrl.sv
// block_sync_ctrl: 64b/66b block-lock FSM driving gearbox slip,
// with saturating header-error and slip statistics.
module block_sync_ctrl #(
  parameter int unsigned SH_CNT_MAX       = 64,
  parameter int unsigned SH_INVLD_MAX     = 16,
  parameter int unsigned SLIP_WAIT_CYCLES = 66
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  head_i,
  input  logic        head_valid_i,
  input  logic        clr_i,
  output logic        slip_o,
  output logic        block_lock_o,
  output logic [15:0] hdr_err_cnt_o,
  output logic [15:0] slip_cnt_o
);

  localparam logic [1:0] TEST_SH   = 2'd0;
  localparam logic [1:0] SLIP      = 2'd1;
  localparam logic [1:0] SLIP_WAIT = 2'd2;

  localparam logic [6:0] CNT_MAX   = 7'(SH_CNT_MAX);
  localparam logic [4:0] INVLD_MAX = 5'(SH_INVLD_MAX);
  localparam logic [6:0] WAIT_LAST = 7'(SLIP_WAIT_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [6:0]  sh_cnt_q, sh_cnt_d;
  logic [4:0]  invld_q, invld_d;
  logic [6:0]  timer_q, timer_d;
  logic        lock_q, lock_d;
  logic        lock_out_q;
  logic        slip_q;
  logic [15:0] hdr_err_q, hdr_err_d;
  logic [15:0] slip_cnt_q, slip_cnt_d;

  logic        hdr_bad;
  logic [6:0]  sh_n;
  logic [4:0]  invld_m;
  logic        err_inc;

  assign hdr_bad = (head_i == 2'b00) || (head_i == 2'b11);
  assign sh_n    = sh_cnt_q + 7'd1;
  assign invld_m = invld_q + {4'd0, hdr_bad};
  assign err_inc = (state_q == TEST_SH) && head_valid_i
                   && hdr_bad && lock_q;

  always_comb begin
    state_d  = state_q;
    sh_cnt_d = sh_cnt_q;
    invld_d  = invld_q;
    timer_d  = timer_q;
    lock_d   = lock_q;
    case (state_q)
      TEST_SH: begin
        if (head_valid_i) begin
          if (!lock_q && hdr_bad) begin
            state_d  = SLIP;
            sh_cnt_d = '0;
            invld_d  = '0;
          end else if (lock_q && invld_m == INVLD_MAX) begin
            lock_d   = 1'b0;
            state_d  = SLIP;
            sh_cnt_d = '0;
            invld_d  = '0;
          end else if (sh_n == CNT_MAX) begin
            lock_d   = 1'b1;
            sh_cnt_d = '0;
            invld_d  = '0;
          end else begin
            sh_cnt_d = sh_n;
            invld_d  = invld_m;
          end
        end
      end
      SLIP: begin
        state_d = SLIP_WAIT;
        timer_d = '0;
      end
      SLIP_WAIT: begin
        if (timer_q == WAIT_LAST) begin
          state_d  = TEST_SH;
          sh_cnt_d = '0;
          invld_d  = '0;
        end else begin
          timer_d = timer_q + 7'd1;
        end
      end
      default: begin
        state_d  = TEST_SH;
        sh_cnt_d = '0;
        invld_d  = '0;
      end
    endcase
  end

  // Statistics: clear beats a same-cycle increment.
  always_comb begin
    hdr_err_d  = hdr_err_q;
    slip_cnt_d = slip_cnt_q;
    if (clr_i) begin
      hdr_err_d  = '0;
      slip_cnt_d = '0;
    end else begin
      if (err_inc && hdr_err_q != 16'hFFFF)
        hdr_err_d = hdr_err_q + 16'd1;
      if (slip_q && slip_cnt_q != 16'hFFFF)
        slip_cnt_d = slip_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= TEST_SH;
      sh_cnt_q   <= '0;
      invld_q    <= '0;
      timer_q    <= '0;
      lock_q     <= 1'b0;
      lock_out_q <= 1'b0;
      slip_q     <= 1'b0;
      hdr_err_q  <= '0;
      slip_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sh_cnt_q   <= sh_cnt_d;
      invld_q    <= invld_d;
      timer_q    <= timer_d;
      lock_q     <= lock_d;
      lock_out_q <= lock_q;
      slip_q     <= (state_q == SLIP);
      hdr_err_q  <= hdr_err_d;
      slip_cnt_q <= slip_cnt_d;
    end
  end

  assign slip_o        = slip_q;
  assign block_lock_o  = lock_out_q;
  assign hdr_err_cnt_o = hdr_err_q;
  assign slip_cnt_o    = slip_cnt_q;

endmodule

// File: tb/tb_block_sync_ctrl.sv
// tb_block_sync_ctrl: vector table, directed corner sequences and
// random traffic checked against an event-scheduled lock model.
module tb_block_sync_ctrl;

  localparam int W = 66;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  head = 2'b00;
  logic        hv = 1'b0;
  logic        clr = 1'b0;
  logic        slip, lock;
  logic [15:0] err, scnt;

  always #5 clk = ~clk;

  block_sync_ctrl #(
    .SH_CNT_MAX(64),
    .SH_INVLD_MAX(16),
    .SLIP_WAIT_CYCLES(W)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .head_i(head),
    .head_valid_i(hv),
    .clr_i(clr),
    .slip_o(slip),
    .block_lock_o(lock),
    .hdr_err_cnt_o(err),
    .slip_cnt_o(scnt)
  );

  typedef struct {
    bit          v;
    logic [1:0]  h;
    bit          c;
    bit          slip;
    bit          lock;
    logic [15:0] scnt;
  } vec_t;

  vec_t tbl [6];

  int vecs = 0;
  int fails = 0;

  // Model: edge index, blind interval end, scheduled slip edge.
  int          t;
  int          blind_until;
  int          slip_edge;
  int          win_n;
  int          win_bad;
  bit          m_lock;
  bit          e_lock;
  bit          e_slip;
  logic [15:0] e_err;
  logic [15:0] e_scnt;
  int          gb_off;
  int          rate;

  function automatic void model_reset();
    t = 0;
    blind_until = 0;
    slip_edge = -100;
    win_n = 0;
    win_bad = 0;
    m_lock = 1'b0;
    e_lock = 1'b0;
    e_slip = 1'b0;
    e_err = 16'd0;
    e_scnt = 16'd0;
  endfunction

  function automatic void start_slip();
    slip_edge = t + 1;
    blind_until = t + 2 + W;
    win_n = 0;
    win_bad = 0;
  endfunction

  function automatic void model_edge(input bit v,
                                     input logic [1:0] h,
                                     input bit c);
    bit bad;
    bit inc_e;
    bit inc_s;
    t++;
    e_lock = m_lock;
    e_slip = (t == slip_edge);
    inc_s = (t == slip_edge + 1);
    inc_e = 1'b0;
    bad = (h == 2'b00) || (h == 2'b11);
    if (v && t >= blind_until) begin
      if (m_lock && bad) inc_e = 1'b1;
      if (!m_lock && bad) begin
        start_slip();
      end else begin
        win_n++;
        if (bad) win_bad++;
        if (m_lock && win_bad == 16) begin
          m_lock = 1'b0;
          start_slip();
        end else if (win_n == 64) begin
          m_lock = 1'b1;
          win_n = 0;
          win_bad = 0;
        end
      end
    end
    if (c) begin
      e_err = 16'd0;
      e_scnt = 16'd0;
    end else begin
      if (inc_e && e_err != 16'hFFFF) e_err++;
      if (inc_s && e_scnt != 16'hFFFF) e_scnt++;
    end
  endfunction

  function automatic logic [33:0] act_pack();
    return {slip, lock, err, scnt};
  endfunction

  task automatic check(input string name,
                       input logic [33:0] a,
                       input logic [33:0] e);
    vecs++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s t=%0d got slip=%b lock=%b err=%0d scnt=%0d want slip=%b lock=%b err=%0d scnt=%0d",
               name, t, a[33], a[32], a[31:16], a[15:0],
               e[33], e[32], e[31:16], e[15:0]);
    end
  endtask

  task automatic chk16(input string name,
                       input logic [15:0] a,
                       input logic [15:0] e);
    vecs++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s t=%0d got %0d want %0d", name, t, a, e);
    end
  endtask

  function automatic logic [1:0] good_h();
    return ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
  endfunction

  task automatic tick(input bit v, input logic [1:0] h, input bit c);
    hv = v;
    head = h;
    clr = c;
    @(posedge clk);
    model_edge(v, h, c);
    @(negedge clk);
    check("cycle", act_pack(), {e_slip, e_lock, e_err, e_scnt});
  endtask

  task automatic good(input int n);
    for (int i = 0; i < n; i++) begin
      tick(1'b1, good_h(), 1'b0);
      tick(1'b0, 2'b00, 1'b0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 2'b11, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    hv = 1'b0;
    clr = 1'b0;
    #1;
    check("reset", act_pack(), 34'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    tbl[0] = '{1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[1] = '{1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[2] = '{1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 16'd0};
    tbl[3] = '{1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 16'd1};
    tbl[4] = '{1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 16'd1};
    tbl[5] = '{1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 16'd1};

    @(posedge clk);
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 6; i++) begin
      tick(tbl[i].v, tbl[i].h, tbl[i].c);
      check("table", act_pack(),
            {tbl[i].slip, tbl[i].lock, 16'd0, tbl[i].scnt});
    end

    // Clean lock on 64 good headers.
    do_reset();
    good(63);
    tick(1'b1, good_h(), 1'b0);
    chk16("prelock", {15'd0, lock}, 16'd0);
    tick(1'b0, 2'b00, 1'b0);
    chk16("lock64", {15'd0, lock}, 16'd1);
    chk16("lock64_slips", scnt, 16'd0);

    // Bad 10th header, slip, blind period, relock.
    do_reset();
    good(9);
    tick(1'b1, 2'b00, 1'b0);
    tick(1'b0, 2'b00, 1'b0);
    chk16("slip_pulse", {15'd0, slip}, 16'd1);
    idle(W + 2);
    good(64);
    chk16("relock", {15'd0, lock}, 16'd1);
    chk16("relock_slips", scnt, 16'd1);

    // 15 bad keeps lock; the 16th drops it.
    do_reset();
    good(64);
    for (int i = 0; i < 15; i++) begin
      tick(1'b1, 2'b00, 1'b0);
      tick(1'b0, 2'b00, 1'b0);
    end
    chk16("bad15_lock", {15'd0, lock}, 16'd1);
    chk16("bad15_err", err, 16'd15);
    tick(1'b1, 2'b11, 1'b0);
    tick(1'b0, 2'b00, 1'b0);
    chk16("bad16_lock", {15'd0, lock}, 16'd0);
    chk16("bad16_err", err, 16'd16);
    chk16("bad16_slip", {15'd0, slip}, 16'd1);
    tick(1'b0, 2'b00, 1'b0);
    chk16("bad16_scnt", scnt, 16'd1);
    idle(10);
    do_reset();

    // Ten windows with 15 bad headers each.
    do_reset();
    good(64);
    for (int w = 0; w < 10; w++) begin
      for (int i = 0; i < 64; i++) begin
        tick(1'b1, (i % 4 == 0 && i < 60) ? 2'b00 : good_h(), 1'b0);
        tick(1'b0, 2'b00, 1'b0);
      end
      chk16("win_lock", {15'd0, lock}, 16'd1);
    end
    chk16("win_err150", err, 16'd150);

    // Saturation and clear-over-increment.
    force dut.hdr_err_q = 16'hFFFF;
    e_err = 16'hFFFF;
    tick(1'b0, 2'b01, 1'b0);
    release dut.hdr_err_q;
    tick(1'b1, 2'b00, 1'b0);
    chk16("err_sat", err, 16'hFFFF);
    tick(1'b0, 2'b00, 1'b0);
    tick(1'b1, 2'b11, 1'b1);
    chk16("err_clr", err, 16'd0);
    do_reset();
    tick(1'b1, 2'b00, 1'b0);
    tick(1'b0, 2'b00, 1'b0);
    tick(1'b0, 2'b00, 1'b1);
    chk16("scnt_clr", scnt, 16'd0);

    // Closed loop with a simple gearbox offset model.
    do_reset();
    gb_off = int'($urandom_range(0, 65));
    for (int c = 0; c < 15000 && !lock; c++) begin
      tick(c[0] == 1'b0,
           (gb_off == 0) ? good_h() : 2'($urandom_range(0, 3)),
           1'b0);
      if (slip) gb_off = (gb_off + 1) % 66;
    end
    chk16("gb_lock", {15'd0, lock}, 16'd1);
    chk16("gb_slips_le66", {15'd0, scnt <= 16'd66}, 16'd1);
    good(100);
    chk16("gb_err", err, 16'd0);
    chk16("gb_hold", {15'd0, lock}, 16'd1);

    // Random traffic with varying error density.
    do_reset();
    rate = 0;
    for (int c = 0; c < 8000; c++) begin
      if (c % 256 == 0) begin
        case ($urandom_range(0, 2))
          0: rate = 0;
          1: rate = 3;
          default: rate = 35;
        endcase
      end
      tick($urandom_range(0, 1) != 0,
           (int'($urandom_range(0, 99)) < rate) ?
             (($urandom_range(0, 1) != 0) ? 2'b00 : 2'b11) : good_h(),
           $urandom_range(0, 299) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule

// File: doc/block_sync_ctrl.md
# block_sync_ctrl

Block-lock controller for the 64b/66b RX gearbox. It watches the 2-bit sync header and header-valid strobe from the gearbox and drives the gearbox `slip_i` input until 66-bit block alignment is found. It then holds lock using the 10GBASE-R rule: lose lock on 16 bad headers within a 64-header window. It also keeps saturating error and slip statistics for the PCS status registers.

## Interface
Parameters:
- `SH_CNT_MAX`, 64: headers per test window.
- `SH_INVLD_MAX`, 16: invalid headers within one window that cause loss of lock.
- `SLIP_WAIT_CYCLES`, 66: clocks to ignore headers after a slip pulse; legal range 4..127.

Ports:
- `clk_i`  in  1  RX user clock, same clock as the gearbox.
- `rst_i`  in  1  asynchronous, active-high reset.
- `head_i`  in  2  sync header from the gearbox.
- `head_valid_i`  in  1  `head_i` is meaningful this cycle; asserted roughly every other cycle.
- `clr_i`  in  1  synchronous clear of both statistic counters.
- `slip_o`  out  1  to the gearbox `slip_i`; single-cycle pulse.
- `block_lock_o`  out  1  block alignment achieved.
- `hdr_err_cnt_o`  out  16  saturating count of invalid headers seen while locked.
- `slip_cnt_o`  out  16  saturating count of slip pulses issued.

## Operation
- A header is valid when `head_i` is 2'b01 or 2'b10. A header is invalid when `head_i` is 2'b00 or 2'b11.
- Internal counters:
  - `sh_cnt` is 7 bits and counts headers in the current window.
  - `sh_invld_cnt` is 5 bits and counts invalid headers in the current window.
- FSM states: TEST_SH, SLIP, SLIP_WAIT. Reset state is TEST_SH with both counters at 0.
- TEST_SH, on a cycle with `head_valid_i`=1 (cycles with `head_valid_i`=0 are ignored):
  - Let n = `sh_cnt`+1.
  - Let m = `sh_invld_cnt` + (1 if the header is invalid, else 0).
  - Unlocked and header invalid: go to SLIP and clear both counters.
  - Locked and m == `SH_INVLD_MAX`: set `block_lock_o`=0, go to SLIP, clear both counters. This rule takes priority over the window-end rule.
  - Otherwise, if n == `SH_CNT_MAX`: clear both counters and stay in TEST_SH. If unlocked, set `block_lock_o`=1 (all headers in the window were valid by construction).
  - Otherwise: `sh_cnt`=n, `sh_invld_cnt`=m.
- SLIP:
  - `slip_o`=1 for exactly this one cycle, and `slip_cnt_o` increments.
  - Next state is SLIP_WAIT; the wait timer loads 0.
- SLIP_WAIT:
  - `slip_o`=0 and headers are ignored, because gearbox alignment settles after the slip edge.
  - The timer increments every clock. When it reaches `SLIP_WAIT_CYCLES`-1, the FSM returns to TEST_SH with both counters at 0.
  - This guarantees `slip_o` stays low for at least 4 cycles between pulses, which the gearbox's rising-edge detect requires.
- `hdr_err_cnt_o` increments on each invalid header sampled in TEST_SH while `block_lock_o`=1. This includes the 16th invalid header, the one that drops lock.
- Both statistic counters saturate at 16'hFFFF with no wrap.
- `clr_i`=1 zeroes both counters. `clr_i` wins over a same-cycle increment; that increment is lost.

## Timing
- Reset values: `slip_o`=0, `block_lock_o`=0, `hdr_err_cnt_o`=0, `slip_cnt_o`=0, FSM=TEST_SH, all internal counters 0.
- All outputs are registered; there is no combinational input-to-output path.
- Invalid header sampled at edge k (unlocked): `slip_o` is high from edge k+1 to edge k+2. `slip_cnt_o` updates at edge k+2.
- Window-completing header sampled at edge k: `block_lock_o` is high from edge k+1.
- Lock-loss header at edge k: `block_lock_o` falls at edge k+1; `slip_o` is high from edge k+1 to edge k+2.
- Slip to next header evaluation: the first header considered is one with `head_valid_i` at or after edge k+2+`SLIP_WAIT_CYCLES`.
- `rst_i` asserted in any state, including mid-pulse: all outputs and state return to reset values immediately (asynchronously). The first evaluation after deassertion happens at the first clock edge with `head_valid_i`=1.
- `block_lock_o` is unchanged in SLIP and SLIP_WAIT. It is 0 there whenever a slip was caused by loss of lock.

## Test plan
- Reset, then `head_i`=2'b01 with `head_valid_i` on alternate cycles → `block_lock_o` rises the cycle after the 64th valid strobe. `slip_o` never asserts; `slip_cnt_o`=0.
- Unlocked, 10th header 2'b00 → one-cycle `slip_o` pulse the next cycle, then 66 cycles of ignored headers. Counting restarts and lock needs 64 further good headers; `slip_cnt_o`=1.
- Locked, 15 invalid headers in one window → stays locked, `hdr_err_cnt_o`=15. The 16th invalid header in the same window → `block_lock_o` falls, one slip pulse, `hdr_err_cnt_o`=16.
- Locked, 15 invalid headers per window across 10 consecutive windows → `block_lock_o` stays 1 throughout, `hdr_err_cnt_o`=150.
- Closed loop with the gearbox, random bit offset, scrambled payload with valid headers → lock achieved with `slip_cnt_o` ≤ 66, and no invalid headers occur after lock.
- `rst_i` pulsed during SLIP_WAIT → outputs 0 immediately. Separately, with `hdr_err_cnt_o` preloaded to 16'hFFFF, an invalid header leaves it at 16'hFFFF; `clr_i` in the same cycle as an increment gives 0.
